// File: rtl/restoring_divider32.sv
// restoring_divider32: iterative 32-bit restoring divider, one quotient bit per clock.
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds the signed_op port).

// adder_substractor32: 32-bit ripple adder/subtractor, M=1 computes A-B (C=1 means no borrow)
module adder_substractor32 (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        M,
    output logic [31:0] S,
    output logic        C,
    output logic        V
);
    logic [32:0] cy;
    assign cy[0] = M;
    for (genvar i = 0; i < 32; i++) begin : g_bit
        logic bx;
        assign bx = B[i] ^ M;
        assign S[i] = A[i] ^ bx ^ cy[i];
        assign cy[i+1] = (A[i] & bx) | (cy[i] & (A[i] ^ bx));
    end
    assign C = cy[32];
    assign V = cy[32] ^ cy[31];
endmodule

module restoring_divider32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic        signed_op,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t      state;
    logic [31:0] q, r, dvs;
    logic [4:0]  cnt;
    logic [31:0] shifted, diff, q_next, r_next;
    logic [31:0] a_in, d_in, q_fin, r_fin;
    logic        carry, succ, sub_v_unused;

    assign shifted = {r[30:0], q[31]};

    adder_substractor32 u_sub (
        .A(shifted),
        .B(dvs),
        .M(1'b1),
        .S(diff),
        .C(carry),
        .V(sub_v_unused)
    );

    // A set R[31] means shifted overflowed 32 bits, so it always exceeds the divisor
    assign succ   = r[31] | carry;
    assign q_next = {q[30:0], succ};
    assign r_next = succ ? diff : shifted;

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign a_in  = (signed_op && dividend[31]) ? -dividend : dividend;
    assign d_in  = (signed_op && divisor[31]) ? -divisor : divisor;
    assign q_fin = neg_q ? -q_next : q_next;
    assign r_fin = neg_r ? -r_next : r_next;

    // Result sign fixups captured at accept: quotient by sign mismatch, remainder follows dividend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == IDLE && start) begin
            neg_q <= signed_op && (dividend[31] ^ divisor[31]);
            neg_r <= signed_op && dividend[31];
        end
    end
`else
    assign a_in  = dividend;
    assign d_in  = divisor;
    assign q_fin = q_next;
    assign r_fin = r_next;
`endif

    // Control FSM and datapath registers; results publish with done on the last RUN edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            q           <= '0;
            r           <= '0;
            dvs         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy        <= 1'b1;
                    div_by_zero <= 1'b0;
                    cnt         <= '0;
                    dvs         <= d_in;
                    if (divisor == '0) begin
                        q     <= '1;
                        r     <= dividend;
                        state <= FINISH;
                    end else begin
                        q     <= a_in;
                        r     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    q   <= q_next;
                    r   <= r_next;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= FINISH;
                    end
                end
                FINISH: if (done) begin
                    state <= IDLE;
                end else begin
                    quotient    <= q;
                    remainder   <= r;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    div_by_zero <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_restoring_divider32.sv
// tb_restoring_divider32: directed + random scoreboard bench for restoring_divider32
module tb_restoring_divider32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;
`ifdef DIV_SIGNED_EN
    logic        signed_op = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    restoring_divider32 dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
`ifdef DIV_SIGNED_EN
        .signed_op(signed_op),
`endif
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d);
        if (d == 32'd0) return exp_t'{q: 32'hFFFFFFFF, r: a, dz: 1'b1};
        return exp_t'{q: a / d, r: a % d, dz: 1'b0};
    endfunction

    // Issue one op, push its expectation, wait (bounded) for done, pop and compare
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input exp_t e, input int poke);
        exp_t got;
        int   lat;
        logic seen;
        @(negedge clk);
        dividend = a;
        divisor  = d;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " busy_after_accept"}, {31'b0, busy}, 32'd1);
            if (lat == poke) begin
                dividend = 32'd1;
                divisor  = 32'd1;
                start    = 1'b1;
            end
            if (lat == poke + 1) start = 1'b0;
            seen = done;
        end
        check({tag, " latency"}, lat, (d == 32'd0) ? 32'd2 : 32'd33);
        got = sb.pop_front();
        check({tag, " quotient"}, quotient, got.q);
        check({tag, " remainder"}, remainder, got.r);
        check({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, got.dz});
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        repeat (2) @(negedge clk);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset dz", {31'b0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run_op("100/7", 32'd100, 32'd7, model(32'd100, 32'd7), 0);
        run_op("max/8000_0001", 32'hFFFFFFFF, 32'h80000001, exp_t'{q: 32'd1, r: 32'h7FFFFFFE, dz: 1'b0}, 0);
        run_op("max/1", 32'hFFFFFFFF, 32'd1, exp_t'{q: 32'hFFFFFFFF, r: 32'd0, dz: 1'b0}, 0);
        run_op("5/0", 32'd5, 32'd0, exp_t'{q: 32'hFFFFFFFF, r: 32'd5, dz: 1'b1}, 0);
        run_op("9/3", 32'd9, 32'd3, exp_t'{q: 32'd3, r: 32'd0, dz: 1'b0}, 0);
        run_op("100/7 poked", 32'd100, 32'd7, exp_t'{q: 32'd14, r: 32'd2, dz: 1'b0}, 10);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignored start extra done", pulses, 32'd0);

        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async reset quotient", quotient, 32'd0);
        check("async reset remainder", remainder, 32'd0);
        check("async reset busy", {31'b0, busy}, 32'd0);
        pulses = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("aborted op done", pulses, 32'd0);
        run_op("50/5", 32'd50, 32'd5, exp_t'{q: 32'd10, r: 32'd0, dz: 1'b0}, 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, d;
            a = $urandom;
            d = (i < 3) ? $urandom_range(1, 1000) : $urandom;
            if (d == 32'd0) d = 32'd1;
            run_op("random", a, d, model(a, d), 0);
        end
        run_op("7/9", 32'd7, 32'd9, model(32'd7, 32'd9), 0);

`ifdef DIV_SIGNED_EN
        signed_op = 1'b1;
        run_op("s -7/2", 32'hFFFFFFF9, 32'd2, exp_t'{q: 32'hFFFFFFFD, r: 32'hFFFFFFFF, dz: 1'b0}, 0);
        run_op("s min/-1", 32'h80000000, 32'hFFFFFFFF, exp_t'{q: 32'h80000000, r: 32'd0, dz: 1'b0}, 0);
        run_op("s -5/0", 32'hFFFFFFFB, 32'd0, exp_t'{q: 32'hFFFFFFFF, r: 32'hFFFFFFFB, dz: 1'b1}, 0);
        signed_op = 1'b0;
`endif

        check("scoreboard drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
